// File: rtl/bin2xs3_seq_if.sv
// Start/busy/done handshake bundle for the sequential binary-to-decimal
// converter. The requester drives the operand; the converter returns the result.
interface bin2xs3_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                start;
    logic                mode;
    logic [WIDTH-1:0]    din;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [4*DIGITS-1:0] dout;

    modport master (
        output start, mode, din,
        input  busy, done, overflow, dout
    );

    modport slave (
        input  start, mode, din,
        output busy, done, overflow, dout
    );
endinterface

// File: rtl/bin2xs3_seq.sv
// Shift-and-add-3 binary to packed decimal converter, one bit per clock,
// with excess-3 or plain BCD output selected per conversion.
module bin2xs3_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin2xs3_seq_if.slave  bus
);
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int TW = DW + WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_bin;
    logic [DW-1:0]   r_dig;
    logic            r_mode;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;
    logic [DW-1:0]   r_dout;
    logic            r_oflow;
    logic            r_done;

    state_t          w_state_n;
    logic [WIDTH-1:0] w_bin_n;
    logic [DW-1:0]   w_dig_n;
    logic            w_mode_n;
    logic [CW-1:0]   w_cnt_n;
    logic            w_ovf_n;
    logic [DW-1:0]   w_dout_n;
    logic            w_oflow_n;
    logic            w_done_n;

    logic [DW-1:0]   w_adj;
    logic [DW-1:0]   w_xs3;
    logic [TW-1:0]   w_cat;
    logic [TW-1:0]   w_sh;

    // Per-digit corrections are independent 4-bit adds; no carry crosses digits.
    always_comb begin
        w_adj = '0;
        w_xs3 = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_adj[4*k +: 4] = (r_dig[4*k +: 4] >= 4'd5)
                            ? r_dig[4*k +: 4] + 4'd3
                            : r_dig[4*k +: 4];
            w_xs3[4*k +: 4] = r_dig[4*k +: 4] + 4'd3;
        end
        w_cat = {w_adj, r_bin};
        w_sh  = w_cat << 1;
    end

    always_comb begin
        w_state_n = r_state;
        w_bin_n   = r_bin;
        w_dig_n   = r_dig;
        w_mode_n  = r_mode;
        w_cnt_n   = r_cnt;
        w_ovf_n   = r_ovf;
        w_dout_n  = r_dout;
        w_oflow_n = r_oflow;
        w_done_n  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_bin_n   = bus.din;
                    w_mode_n  = bus.mode;
                    w_dig_n   = '0;
                    w_ovf_n   = 1'b0;
                    w_cnt_n   = CW'(WIDTH);
                    w_state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_dig_n = w_sh[TW-1:WIDTH];
                w_bin_n = w_sh[WIDTH-1:0];
                // Bit shifted out of the top digit means the value exceeds 10^DIGITS.
                w_ovf_n = r_ovf | w_adj[DW-1];
                w_cnt_n = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_n = S_FINISH;
                end
            end
            S_FINISH: begin
                w_dout_n  = r_mode ? w_xs3 : r_dig;
                w_oflow_n = r_ovf;
                w_done_n  = 1'b1;
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_dig   <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_dout  <= '0;
            r_oflow <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_bin   <= w_bin_n;
            r_dig   <= w_dig_n;
            r_mode  <= w_mode_n;
            r_cnt   <= w_cnt_n;
            r_ovf   <= w_ovf_n;
            r_dout  <= w_dout_n;
            r_oflow <= w_oflow_n;
            r_done  <= w_done_n;
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.overflow = r_oflow;
    assign bus.dout     = r_dout;
endmodule

// File: tb/tb_bin2xs3_seq.sv
// Scoreboard bench for bin2xs3_seq: three- and two-digit instances,
// directed vectors, abort by reset and a full reference sweep.
module tb_bin2xs3_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bin2xs3_seq_if #(.WIDTH(8), .DIGITS(3)) if3 ();
    bin2xs3_seq_if #(.WIDTH(8), .DIGITS(2)) if2 ();

    bin2xs3_seq #(.WIDTH(8), .DIGITS(3)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    bin2xs3_seq #(.WIDTH(8), .DIGITS(2)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    typedef struct packed {
        logic [11:0] d;
        logic        o;
    } exp3_t;

    typedef struct packed {
        logic [7:0] d;
        logic       o;
    } exp2_t;

    exp3_t exp3[$];
    exp2_t exp2[$];
    int    done_cyc3[$];

    int cmp_n  = 0;
    int mism_n = 0;
    int cyc    = 0;
    int starts3 = 0;
    int starts2 = 0;
    int dones3  = 0;
    int dones2  = 0;
    logic prev3 = 1'b0;
    logic prev2 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            mism_n++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a done pulse is presented.
    always @(negedge clk) begin
        if (if3.done) begin
            chk("done3_single", {31'd0, prev3}, 32'd0);
            dones3++;
            done_cyc3.push_back(cyc);
            if (exp3.size() == 0) begin
                chk("done3_unexpected", 32'd1, 32'd0);
            end else begin
                exp3_t e;
                e = exp3.pop_front();
                chk("dout3", {20'd0, if3.dout}, {20'd0, e.d});
                chk("ovf3", {31'd0, if3.overflow}, {31'd0, e.o});
            end
        end
        if (if2.done) begin
            chk("done2_single", {31'd0, prev2}, 32'd0);
            dones2++;
            if (exp2.size() == 0) begin
                chk("done2_unexpected", 32'd1, 32'd0);
            end else begin
                exp2_t e;
                e = exp2.pop_front();
                chk("dout2", {24'd0, if2.dout}, {24'd0, e.d});
                chk("ovf2", {31'd0, if2.overflow}, {31'd0, e.o});
            end
        end
        prev3 <= if3.done;
        prev2 <= if2.done;
    end

    task automatic issue3(input logic [7:0] d, input logic m,
                          input logic [11:0] e, input logic o,
                          input bit push);
        if3.din   = d;
        if3.mode  = m;
        if3.start = 1'b1;
        if (push) begin
            exp3.push_back({e, o});
            starts3++;
        end
        @(posedge clk); #1;
        if3.start = 1'b0;
    endtask

    task automatic issue2(input logic [7:0] d, input logic m,
                          input logic [7:0] e, input logic o);
        if2.din   = d;
        if2.mode  = m;
        if2.start = 1'b1;
        exp2.push_back({e, o});
        starts2++;
        @(posedge clk); #1;
        if2.start = 1'b0;
    endtask

    task automatic wait3(output int n);
        n = 0;
        while (if3.busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        if (if3.busy) chk("timeout3", 32'd1, 32'd0);
    endtask

    task automatic wait2();
        int n;
        n = 0;
        while (if2.busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        if (if2.busy) chk("timeout2", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        logic [11:0] ref_d;
        int v;
        if3.start = 1'b0; if3.mode = 1'b0; if3.din = '0;
        if2.start = 1'b0; if2.mode = 1'b0; if2.din = '0;

        #2;
        chk("rst_busy", {31'd0, if3.busy}, 32'd0);
        chk("rst_done", {31'd0, if3.done}, 32'd0);
        chk("rst_ovf", {31'd0, if3.overflow}, 32'd0);
        chk("rst_dout", {20'd0, if3.dout}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue3(8'd255, 1'b1, 12'h588, 1'b0, 1);
        wait3(n);
        chk("busy_cycles_xs3", n, 32'd9);
        chk("done_at_busy_fall", {31'd0, if3.done}, 32'd1);
        issue3(8'd255, 1'b0, 12'h255, 1'b0, 1);
        wait3(n);
        chk("busy_cycles_bcd", n, 32'd9);
        @(posedge clk); #1;

        base = done_cyc3.size();
        issue3(8'd0, 1'b1, 12'h333, 1'b0, 1);
        wait3(n);
        issue3(8'd9, 1'b1, 12'h33C, 1'b0, 1);
        wait3(n);
        issue3(8'd100, 1'b0, 12'h100, 1'b0, 1);
        wait3(n);
        @(negedge clk); #1;
        chk("b2b_count", done_cyc3.size() - base, 32'd3);
        if (done_cyc3.size() == base + 3) begin
            chk("b2b_space1", done_cyc3[base+1] - done_cyc3[base], 32'd10);
            chk("b2b_space2", done_cyc3[base+2] - done_cyc3[base+1], 32'd10);
        end
        @(posedge clk); #1;

        issue2(8'd200, 1'b0, 8'h00, 1'b1);
        wait2();
        issue2(8'd123, 1'b0, 8'h23, 1'b1);
        wait2();
        issue2(8'd99, 1'b0, 8'h99, 1'b0);
        wait2();
        issue2(8'd150, 1'b1, 8'h83, 1'b1);
        wait2();
        @(posedge clk); #1;

        issue3(8'd77, 1'b0, 12'h077, 1'b0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if3.din   = 8'd200;
        if3.mode  = 1'b1;
        if3.start = 1'b1;
        @(posedge clk); #1;
        if3.start = 1'b0;
        wait3(n);
        repeat (15) @(posedge clk);
        #1;
        chk("ignored_start_idle", {31'd0, if3.busy}, 32'd0);

        issue3(8'd150, 1'b1, 12'h000, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, if3.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, if3.done}, 32'd0);
        chk("mid_rst_ovf", {31'd0, if3.overflow}, 32'd0);
        chk("mid_rst_dout", {20'd0, if3.dout}, 32'd0);
        chk("mid_rst_dout2", {24'd0, if2.dout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'd0, if3.busy}, 32'd0);
        issue3(8'd42, 1'b1, 12'h375, 1'b0, 1);
        wait3(n);
        @(posedge clk); #1;

        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 256; d++) begin
                v = d;
                ref_d = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
                if (m == 1) ref_d = ref_d + 12'h333;
                issue3(8'(d), 1'(m), ref_d, 1'b0, 1);
                wait3(n);
            end
        end
        repeat (3) @(posedge clk);
        #1;

        chk("done_count3", dones3, starts3);
        chk("done_count2", dones2, starts2);
        chk("sb3_empty", exp3.size(), 32'd0);
        chk("sb2_empty", exp2.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, mism_n);
        $finish;
    end
endmodule
